dcache_snoop_responder: RTL and testbench



---
 rtl/dcache_snoop_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_dcache_snoop_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module      : dcache_snoop_responder
// Description : Cache-side coherence agent. Answers snoops that the memory
//               controller issues through ccwait/ccsnoopaddr/ccinv: looks the
//               block up in the dcache frame arrays, encodes the result on
//               cctrans/ccwrite, supplies both block words on a hit, and then
//               cleans or invalidates the frame. Outside snoops the core's
//               own bus request is passed through on cctrans/ccwrite.
// Ports       : CLK, nRST           - clock (rising edge), async active-low reset
//               ccwait, ccinv,
//               ccsnoopaddr         - snoop hold, invalidate request, address
//               dwait               - low when the supplied word was accepted
//               cache_req, cache_rw - core bus request and write intent
//               frm_valid/dirty/
//               tag/data            - frame contents of set snp_idx
//               cctrans, ccwrite    - request pass-through / snoop response
//               snp_daddr,
//               snp_dstore          - address and data of supplied word
//               snp_active          - core stall / frame-write lockout
//               snp_idx             - set index for the frame lookup
//               upd_en/way/
//               valid/dirty         - one-cycle frame state update
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_snoop_responder #(
  parameter  int SETS = 8,
  parameter  int WAYS = 2,
  localparam int IDXW = $clog2(SETS),
  localparam int TAGW = 32 - IDXW - 3,
  localparam int WAYW = $clog2(WAYS)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 ccwait,
  input  logic                 ccinv,
  input  logic [31:0]          ccsnoopaddr,
  input  logic                 dwait,
  input  logic                 cache_req,
  input  logic                 cache_rw,
  input  logic [WAYS-1:0]      frm_valid,
  input  logic [WAYS-1:0]      frm_dirty,
  input  logic [WAYS*TAGW-1:0] frm_tag,
  input  logic [WAYS*64-1:0]   frm_data,
  output logic                 cctrans,
  output logic                 ccwrite,
  output logic [31:0]          snp_daddr,
  output logic [31:0]          snp_dstore,
  output logic                 snp_active,
  output logic [IDXW-1:0]      snp_idx,
  output logic                 upd_en,
  output logic [WAYW-1:0]      upd_way,
  output logic                 upd_valid,
  output logic                 upd_dirty
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOOKUP  = 3'd1;
  localparam logic [2:0] SUPPLY0 = 3'd2;
  localparam logic [2:0] SUPPLY1 = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  logic [2:0]      r_state;
  logic [31:3]     r_addr;   // block address; byte/word offset is regenerated
  logic [WAYW-1:0] r_way;
  logic            r_hit;
  logic            r_dirty;
  logic            r_inv;

  // Word/byte offset of the snoop address is not needed once the block is known.
  logic w_unused_ok;
  assign w_unused_ok = ^ccsnoopaddr[2:0];

  // --------------------------------------------------------------------------
  // Tag compare on the latched address. Iterating from the top way down lets
  // the lowest hitting way win if several ways (illegally) match.
  // --------------------------------------------------------------------------
  logic            w_hit;
  logic [WAYW-1:0] w_way;
  logic            w_hit_dirty;

  always_comb begin
    w_hit = 1'b0;
    w_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (frm_valid[w] && (frm_tag[w*TAGW +: TAGW] == r_addr[31:IDXW+3])) begin
        w_hit = 1'b1;
        w_way = WAYW'(w);
      end
    end
    w_hit_dirty = w_hit & frm_dirty[w_way];
  end

  logic [63:0] w_blk;
  assign w_blk = frm_data[{r_way, 6'd0} +: 64];

  // A dirty supplier must wait for the bus to take each word; a clean
  // supplier's data is redundant with memory, so it just paces one per cycle.
  logic w_word_done;
  assign w_word_done = ~r_dirty | ~dwait;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_way   <= '0;
      r_hit   <= 1'b0;
      r_dirty <= 1'b0;
      r_inv   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ccwait) begin
            r_addr  <= ccsnoopaddr[31:3];
            r_inv   <= ccinv;
            r_way   <= '0;
            r_hit   <= 1'b0;
            r_dirty <= 1'b0;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_inv <= r_inv | ccinv;
          if (!ccwait) begin
            r_state <= IDLE;
          end else begin
            r_way   <= w_way;
            r_hit   <= w_hit;
            r_dirty <= w_hit_dirty;
            r_state <= w_hit ? SUPPLY0 : RELEASE;
          end
        end
        SUPPLY0: begin
          r_inv <= r_inv | ccinv;
          if (!ccwait)         r_state <= IDLE;
          else if (w_word_done) r_state <= SUPPLY1;
        end
        SUPPLY1: begin
          r_inv <= r_inv | ccinv;
          if (!ccwait)         r_state <= IDLE;
          else if (w_word_done) r_state <= RELEASE;
        end
        RELEASE: begin
          r_inv <= r_inv | ccinv;
          if (!ccwait) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  logic            w_cctrans;
  logic            w_ccwrite;
  logic [31:0]     w_daddr;
  logic [31:0]     w_dstore;
  logic [IDXW-1:0] w_idx;
  logic            w_upd_en;
  logic            w_inv_now;

  assign w_inv_now = r_inv | ccinv;

  always_comb begin
    w_cctrans = 1'b0;
    w_ccwrite = 1'b0;
    w_daddr   = '0;
    w_dstore  = '0;
    w_upd_en  = 1'b0;
    w_idx     = r_addr[IDXW+2:3];
    case (r_state)
      IDLE: begin
        w_idx     = ccsnoopaddr[IDXW+2:3];
        w_cctrans = cache_req & ~ccwait;
        w_ccwrite = cache_rw & cache_req & ~ccwait;
      end
      LOOKUP: begin
        // miss -> 10, clean hit -> 00, dirty hit -> 11
        w_cctrans = ~w_hit | w_hit_dirty;
        w_ccwrite = w_hit_dirty;
      end
      SUPPLY0: begin
        w_cctrans = r_dirty;
        w_ccwrite = r_dirty;
        w_daddr   = {r_addr[31:3], 3'b000};
        w_dstore  = w_blk[31:0];
      end
      SUPPLY1: begin
        w_cctrans = r_dirty;
        w_ccwrite = r_dirty;
        w_daddr   = {r_addr[31:3], 3'b100};
        w_dstore  = w_blk[63:32];
      end
      RELEASE: begin
        // A clean, still-valid frame needs no change, so no strobe for it.
        w_upd_en = r_hit & ~ccwait & (w_inv_now | r_dirty);
      end
      default: ;
    endcase
  end

  // All outputs, including the input-driven pass-through paths, are held
  // low while reset is asserted.
  assign cctrans    = nRST & w_cctrans;
  assign ccwrite    = nRST & w_ccwrite;
  assign snp_daddr  = nRST ? w_daddr  : '0;
  assign snp_dstore = nRST ? w_dstore : '0;
  assign snp_active = nRST & ((r_state != IDLE) | ccwait);
  assign snp_idx    = nRST ? w_idx : '0;
  assign upd_en     = nRST & w_upd_en;
  assign upd_way    = upd_en ? r_way : '0;
  assign upd_valid  = upd_en & ~w_inv_now;
  assign upd_dirty  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_dcache_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_snoop_responder
// Description : Directed self-checking bench for dcache_snoop_responder.
//               Set 2 holds way0 (tag 0x055) and way1 (tag 0x123); every
//               other set is empty, so a wrong snp_idx turns hits into misses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_snoop_responder;

  localparam int SETS = 8;
  localparam int WAYS = 2;
  localparam int TAGW = 26;

  localparam logic [31:0] C_HIT_ADDR  = 32'h0000_48D0; // tag 0x123, idx 2
  localparam logic [31:0] C_MISS_ADDR = 32'h0000_4910; // tag 0x124, idx 2

  logic              CLK = 1'b0;
  logic              nRST;
  logic              ccwait, ccinv, dwait, cache_req, cache_rw;
  logic [31:0]       ccsnoopaddr;
  logic [WAYS-1:0]   frm_valid, frm_dirty;
  logic [WAYS*TAGW-1:0] frm_tag;
  logic [WAYS*64-1:0]   frm_data;
  logic              cctrans, ccwrite, snp_active, upd_en, upd_valid, upd_dirty;
  logic [31:0]       snp_daddr, snp_dstore;
  logic [2:0]        snp_idx;
  logic [0:0]        upd_way;

  logic              cfg_dirty;
  int                checks   = 0;
  int                failures = 0;

  always #5 CLK = ~CLK;

  // Frame array model: only set 2 holds anything.
  always_comb begin
    frm_tag   = {26'h123, 26'h055};
    frm_data  = {64'hBBBB1111_AAAA0000, 64'h22222222_11111111};
    frm_valid = 2'b00;
    frm_dirty = 2'b00;
    if (snp_idx == 3'd2) begin
      frm_valid = 2'b11;
      frm_dirty = {cfg_dirty, 1'b1};
    end
  end

  dcache_snoop_responder #(.SETS(SETS), .WAYS(WAYS)) dut (
    .CLK(CLK), .nRST(nRST),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .dwait(dwait),
    .cache_req(cache_req), .cache_rw(cache_rw),
    .frm_valid(frm_valid), .frm_dirty(frm_dirty), .frm_tag(frm_tag), .frm_data(frm_data),
    .cctrans(cctrans), .ccwrite(ccwrite), .snp_daddr(snp_daddr), .snp_dstore(snp_dstore),
    .snp_active(snp_active), .snp_idx(snp_idx),
    .upd_en(upd_en), .upd_way(upd_way), .upd_valid(upd_valid), .upd_dirty(upd_dirty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1
  // unit later, well clear of the next edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b1;
    cache_req = 1'b0; cache_rw = 1'b0; ccsnoopaddr = '0; cfg_dirty = 1'b1;
    #12;
    chk("rst_cctrans", {31'd0, cctrans}, 32'd0);
    chk("rst_active",  {31'd0, snp_active}, 32'd0);
    chk("rst_upd_en",  {31'd0, upd_en}, 32'd0);
    chk("rst_daddr",   snp_daddr, 32'd0);
    cyc(); nRST = 1'b1;

    // ---- dirty hit, invalidate requested in RELEASE ----
    cyc(); ccwait = 1'b1; ccsnoopaddr = C_HIT_ADDR; dwait = 1'b1; #1;
    chk("t1_active_same_cycle", {31'd0, snp_active}, 32'd1);
    chk("t1_idx", {29'd0, snp_idx}, 32'd2);
    cyc(); #1; // LOOKUP
    chk("t1_lookup_cctrans", {31'd0, cctrans}, 32'd1);
    chk("t1_lookup_ccwrite", {31'd0, ccwrite}, 32'd1);
    cyc(); #1; // SUPPLY0, bus not ready
    chk("t1_s0_daddr",  snp_daddr,  32'h0000_48D0);
    chk("t1_s0_dstore", snp_dstore, 32'hAAAA_0000);
    cyc(); dwait = 1'b0; #1; // SUPPLY0 held
    chk("t1_s0_hold", snp_dstore, 32'hAAAA_0000);
    chk("t1_s0_ccwrite", {31'd0, ccwrite}, 32'd1);
    cyc(); dwait = 1'b1; #1; // SUPPLY1
    chk("t1_s1_daddr",  snp_daddr,  32'h0000_48D4);
    chk("t1_s1_dstore", snp_dstore, 32'hBBBB_1111);
    cyc(); dwait = 1'b0; #1; // SUPPLY1, accepted
    chk("t1_s1_hold", snp_dstore, 32'hBBBB_1111);
    cyc(); dwait = 1'b1; ccinv = 1'b1; #1; // RELEASE
    chk("t1_rel_cctrans", {31'd0, cctrans}, 32'd0);
    chk("t1_rel_no_upd_while_wait", {31'd0, upd_en}, 32'd0);
    cyc(); ccinv = 1'b0; ccwait = 1'b0; #1;
    chk("t1_upd_en",    {31'd0, upd_en}, 32'd1);
    chk("t1_upd_way",   {31'd0, upd_way}, 32'd1);
    chk("t1_upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("t1_upd_dirty", {31'd0, upd_dirty}, 32'd0);
    cyc(); #1; // IDLE
    chk("t1_idle_upd",    {31'd0, upd_en}, 32'd0);
    chk("t1_idle_active", {31'd0, snp_active}, 32'd0);

    // ---- clean hit, no invalidate, dwait ignored ----
    cfg_dirty = 1'b0;
    cyc(); ccwait = 1'b1; ccsnoopaddr = C_HIT_ADDR; dwait = 1'b1; #1;
    cyc(); #1; // LOOKUP
    chk("t2_lookup_cctrans", {31'd0, cctrans}, 32'd0);
    chk("t2_lookup_ccwrite", {31'd0, ccwrite}, 32'd0);
    cyc(); #1;
    chk("t2_s0_dstore", snp_dstore, 32'hAAAA_0000);
    cyc(); #1;
    chk("t2_s1_dstore", snp_dstore, 32'hBBBB_1111);
    chk("t2_s1_daddr",  snp_daddr,  32'h0000_48D4);
    cyc(); #1; // RELEASE
    chk("t2_rel_daddr", snp_daddr, 32'd0);
    cyc(); ccwait = 1'b0; #1;
    chk("t2_no_upd", {31'd0, upd_en}, 32'd0);
    cyc(); #1;

    // ---- dirty hit, no invalidate -> cleaned to shared ----
    cfg_dirty = 1'b1;
    cyc(); ccwait = 1'b1; ccsnoopaddr = C_HIT_ADDR; dwait = 1'b0; #1;
    cyc(); #1; // LOOKUP
    cyc(); #1; // SUPPLY0
    cyc(); #1; // SUPPLY1
    chk("t3_s1_dstore", snp_dstore, 32'hBBBB_1111);
    cyc(); ccwait = 1'b0; #1; // RELEASE, released
    chk("t3_upd_en",    {31'd0, upd_en}, 32'd1);
    chk("t3_upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("t3_upd_dirty", {31'd0, upd_dirty}, 32'd0);
    chk("t3_upd_way",   {31'd0, upd_way}, 32'd1);
    cyc(); dwait = 1'b1; #1;

    // ---- miss ----
    cyc(); ccwait = 1'b1; ccsnoopaddr = C_MISS_ADDR; #1;
    cyc(); #1; // LOOKUP
    chk("t4_lookup_cctrans", {31'd0, cctrans}, 32'd1);
    chk("t4_lookup_ccwrite", {31'd0, ccwrite}, 32'd0);
    cyc(); #1; // RELEASE
    chk("t4_rel_cctrans", {31'd0, cctrans}, 32'd0);
    chk("t4_rel_dstore",  snp_dstore, 32'd0);
    cyc(); ccwait = 1'b0; #1;
    chk("t4_no_upd", {31'd0, upd_en}, 32'd0);
    cyc(); #1;

    // ---- core request masking ----
    cache_req = 1'b1; cache_rw = 1'b1; #1;
    chk("t5_req_cctrans", {31'd0, cctrans}, 32'd1);
    chk("t5_req_ccwrite", {31'd0, ccwrite}, 32'd1);
    ccwait = 1'b1; ccsnoopaddr = C_MISS_ADDR; #1;
    chk("t5_mask_cctrans", {31'd0, cctrans}, 32'd0);
    chk("t5_mask_ccwrite", {31'd0, ccwrite}, 32'd0);
    chk("t5_mask_active",  {31'd0, snp_active}, 32'd1);
    cyc(); #1; // LOOKUP: miss response, not the request
    chk("t5_lookup_ccwrite", {31'd0, ccwrite}, 32'd0);
    cyc(); #1; // RELEASE
    chk("t5_rel_cctrans", {31'd0, cctrans}, 32'd0);
    ccwait = 1'b0;
    cyc(); #1; // IDLE
    chk("t5_back_cctrans", {31'd0, cctrans}, 32'd1);
    chk("t5_back_ccwrite", {31'd0, ccwrite}, 32'd1);
    cache_req = 1'b0; cache_rw = 1'b0;

    // ---- abort in SUPPLY0 ----
    cyc(); ccwait = 1'b1; ccsnoopaddr = C_HIT_ADDR; dwait = 1'b1; #1;
    cyc(); #1; // LOOKUP
    cyc(); ccwait = 1'b0; #1; // SUPPLY0, released early
    chk("t6_s0_no_upd", {31'd0, upd_en}, 32'd0);
    cyc(); #1;
    chk("t6_idle_active", {31'd0, snp_active}, 32'd0);
    chk("t6_idle_daddr",  snp_daddr, 32'd0);
    chk("t6_idle_upd",    {31'd0, upd_en}, 32'd0);

    // ---- reset during SUPPLY0 ----
    cyc(); ccwait = 1'b1; ccsnoopaddr = C_HIT_ADDR; cache_req = 1'b1; #1;
    cyc(); #1; // LOOKUP
    cyc(); #1; // SUPPLY0
    chk("t7_s0_daddr", snp_daddr, 32'h0000_48D0);
    #1; nRST = 1'b0; #1;
    chk("t7_rst_active", {31'd0, snp_active}, 32'd0);
    chk("t7_rst_daddr",  snp_daddr, 32'd0);
    chk("t7_rst_dstore", snp_dstore, 32'd0);
    chk("t7_rst_cctrans", {31'd0, cctrans}, 32'd0);
    ccwait = 1'b0;
    cyc(); nRST = 1'b1; #1;
    chk("t7_post_active",  {31'd0, snp_active}, 32'd0);
    chk("t7_post_cctrans", {31'd0, cctrans}, 32'd1);
    cyc(); #1;
    chk("t7_post_upd", {31'd0, upd_en}, 32'd0);
    cache_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
